// File: rtl/sobel_stream_ctrl_if.sv
// Pixel-in / result-out stream bundle for sobel_stream_ctrl.
// The controller takes the slave view; the source/sink side takes the master view.
interface sobel_stream_ctrl_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_pix;
  logic             out_last;

  modport master (
    output in_valid, in_pix, in_sof, out_ready,
    input  in_ready, out_valid, out_pix, out_last
  );

  modport slave (
    input  in_valid, in_pix, in_sof, out_ready,
    output in_ready, out_valid, out_pix, out_last
  );
endinterface

// File: rtl/sobel_stream_ctrl.sv
// Raster-stream scheduler for the sobel core: line buffers, 3x3 window, result FIFO.
// Optional SOBEL_THRESH_EN adds a thresh port and turns results into a binary edge map.
module sobel_stream_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_stream_ctrl_if.slave bus,
  output logic [PIX_W:0]     p0,
  output logic [PIX_W:0]     p1,
  output logic [PIX_W:0]     p2,
  output logic [PIX_W:0]     p3,
  output logic [PIX_W:0]     p5,
  output logic [PIX_W:0]     p6,
  output logic [PIX_W:0]     p7,
  output logic [PIX_W:0]     p8,
  input  logic [7:0]         core_out
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [7:0]         thresh
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef struct packed {
    logic [7:0] pix;
    logic       last;
  } entry_t;

  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic             accept, produce, is_last;
  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] top, mid, bot;
  logic [PIX_W-1:0] win_q [9];
  logic             st1_q, st1_last_q, st2_q, st2_last_q;
  entry_t           fifo_q [2];
  logic             wr_q, rd_q, push, pop;
  logic [1:0]       count_q, count_d;
  logic [2:0]       used_credit;
  logic [7:0]       push_pix;

  // Pipeline stages st1/st2 cover the two edges between accept and push, so
  // both count against the 2-entry FIFO.
  assign used_credit  = {1'b0, count_q} + {2'b00, st1_q} + {2'b00, st2_q};
  assign bus.in_ready = (used_credit < 3'd2);
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cur_col = bus.in_sof ? '0 : col_q;
    cur_row = bus.in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  assign produce = accept && (cur_col >= CW'(2)) && (cur_row >= RW'(2));
  assign is_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

  assign top = lb1_q[cur_col];
  assign mid = lb0_q[cur_col];
  assign bot = bus.in_pix;

  // NOTE: line buffers have no reset so they map onto RAM; rows 0-1 of every
  // frame refill them before any result depends on their contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[cur_col] <= lb0_q[cur_col];
      lb0_q[cur_col] <= bus.in_pix;
    end
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      st1_q      <= 1'b0;
      st1_last_q <= 1'b0;
      st2_q      <= 1'b0;
      st2_last_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      st1_q      <= produce;
      st1_last_q <= produce && is_last;
      st2_q      <= st1_q;
      st2_last_q <= st1_last_q;
      if (accept) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= top;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= mid;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= bot;
      end
    end
  end

  assign p0 = {1'b0, win_q[0]};
  assign p1 = {1'b0, win_q[1]};
  assign p2 = {1'b0, win_q[2]};
  assign p3 = {1'b0, win_q[3]};
  assign p5 = {1'b0, win_q[5]};
  assign p6 = {1'b0, win_q[6]};
  assign p7 = {1'b0, win_q[7]};
  assign p8 = {1'b0, win_q[8]};

`ifdef SOBEL_THRESH_EN
  assign push_pix = (core_out >= thresh) ? 8'hFF : 8'h00;
`else
  assign push_pix = core_out;
`endif

  assign push = st2_q;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // The two FIFO entries are reset so out_pix/out_last read as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= '{pix: push_pix, last: st2_last_q};
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      count_q <= count_d;
    end
  end

  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_pix   = fifo_q[rd_q].pix;
  assign bus.out_last  = fifo_q[rd_q].last;

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Self-checking bench for sobel_stream_ctrl on a 4x4 image with a behavioural sobel core.
// Table-driven frames plus hand-written latency, backpressure, sof and reset sequences.
`timescale 1ns/1ps
module tb_sobel_stream_ctrl;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int PW   = 8;
  localparam int NPIX = W * H;
  localparam int NRES = (W - 2) * (H - 2);

  typedef struct {
    string name;
    int    base;
    int    dx;
    int    dy;
    int    ecol;
    int    erow;
    int    exp_pix [NRES];
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_stream_ctrl_if #(.PIX_W(PW)) bus ();
  logic [PW:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic [7:0]  core_out;
  logic        core_force_en = 1'b0;
  logic [7:0]  core_force_val = 8'd0;
  int          core_mag_q = 0;
`ifdef SOBEL_THRESH_EN
  logic [7:0]  thresh = 8'd50;
`endif

  sobel_stream_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .p0       (p0),
    .p1       (p1),
    .p2       (p2),
    .p3       (p3),
    .p5       (p5),
    .p6       (p6),
    .p7       (p7),
    .p8       (p8),
    .core_out (core_out)
`ifdef SOBEL_THRESH_EN
    ,
    .thresh   (thresh)
`endif
  );

  int checks = 0;
  int failures = 0;
  int img [NPIX];
  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];
  vec_t vecs [8];
  bit frames_done = 1'b0;

  function automatic int sob(int a0, int a1, int a2, int a3, int a5, int a6, int a7, int a8);
    int gx, gy, m;
    gx = (a2 + 2 * a5 + a8) - (a0 + 2 * a3 + a6);
    gy = (a6 + 2 * a7 + a8) - (a0 + 2 * a1 + a2);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  // Behavioural core: registers the window, magnitude read combinationally.
  always @(posedge clk)
    core_mag_q <= sob(int'(p0), int'(p1), int'(p2), int'(p3), int'(p5), int'(p6), int'(p7), int'(p8));
  assign core_out = core_force_en ? core_force_val : 8'(core_mag_q);

  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_pix, bus.out_last});

  function automatic logic [7:0] exp_map(int raw);
`ifdef SOBEL_THRESH_EN
    return (raw >= int'(thresh)) ? 8'hFF : 8'h00;
`else
    return 8'(raw);
`endif
  endfunction

  function automatic vec_t mk(string n, int b, int dx, int dy, int ec, int er,
                              int e0, int e1, int e2, int e3);
    vec_t v;
    v.name = n; v.base = b; v.dx = dx; v.dy = dy; v.ecol = ec; v.erow = er;
    v.exp_pix[0] = e0; v.exp_pix[1] = e1; v.exp_pix[2] = e2; v.exp_pix[3] = e3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fill_vec(input vec_t v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r * W + c] = v.base + v.dx * c + v.dy * r + (c >= 2 ? v.ecol : 0) + (r >= 2 ? v.erow : 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
  endtask

  task automatic build_exp();
    int raw;
    for (int y = 2; y < H; y++)
      for (int x = 2; x < W; x++) begin
        raw = sob(img[(y-2)*W+x-2], img[(y-2)*W+x-1], img[(y-2)*W+x],
                  img[(y-1)*W+x-2], img[(y-1)*W+x],
                  img[y*W+x-2], img[y*W+x-1], img[y*W+x]);
        exp_q.push_back({exp_map(raw), (x == W - 1) && (y == H - 1)});
      end
  endtask

  task automatic send_pix(input int pix, input logic sof);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pix   = 8'(pix);
    bus.in_sof   = sof;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for pixel %0d", pix);
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_max);
    for (int i = lo; i <= hi; i++) begin
      if (gap_max > 0)
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      send_pix(img[i], i == 0);
    end
  endtask

  task automatic drain_compare(input string name);
    for (int i = 0; i < 500 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_pix%0d", name, i), got_q[i][8:1], exp_q[i][8:1]);
      check($sformatf("%s_last%0d", name, i), got_q[i][0], exp_q[i][0]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pix    = '0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0] = mk("flat",     10,   0,  0,   0,   0,   0,   0,   0,   0);
    vecs[1] = mk("vedge",     0,   0,  0, 100,   0, 255, 255, 255, 255);
    vecs[2] = mk("hedge",     0,   0,  0,   0, 100, 255, 255, 255, 255);
    vecs[3] = mk("xramp",     0,  10,  0,   0,   0,  80,  80,  80,  80);
    vecs[4] = mk("yramp",     0,   0,  5,   0,   0,  40,  40,  40,  40);
    vecs[5] = mk("xyramp",    7,  10,  5,   0,   0, 120, 120, 120, 120);
    vecs[6] = mk("steep",     0,  40,  0,   0,   0, 255, 255, 255, 255);
    vecs[7] = mk("negramp", 100, -10, -5,   0,   0, 120, 120, 120, 120);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_pix", bus.out_pix, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_p0", p0, 0);
    check("rst_p8", p8, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    foreach (vecs[i]) begin
      fill_vec(vecs[i]);
      for (int k = 0; k < NRES; k++)
        exp_q.push_back({exp_map(vecs[i].exp_pix[k]), k == NRES - 1});
      send_range(0, NPIX - 1, 0);
      drain_compare(vecs[i].name);
    end

    // Latency: out_valid rises two edges after the accept of pixel (2,2).
    fill_vec(vecs[0]);
    build_exp();
    send_range(0, 10, 0);
    @(negedge clk);
    check("lat_cycle1", bus.out_valid, 0);
    @(negedge clk);
    check("lat_cycle2", bus.out_valid, 0);
    @(negedge clk);
    check("lat_cycle3", bus.out_valid, 1);
    @(posedge clk);
    #1;
    send_range(11, NPIX - 1, 0);
    drain_compare("latency");

    // Backpressure: two results fill the credit, then everything drains in order.
    bus.out_ready = 1'b0;
    fill_random();
    build_exp();
    send_range(0, 11, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_none_taken", got_q.size(), 0);
    bus.out_ready = 1'b1;
    send_range(12, NPIX - 1, 0);
    drain_compare("bp");

    // Three back-to-back random frames with random input gaps and output stalls.
    frames_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          fill_random();
          build_exp();
          send_range(0, NPIX - 1, 2);
        end
        frames_done = 1'b1;
      end
      begin
        while (!frames_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain_compare("rand");

    // in_sof on the 8th pixel restarts the frame.
    fill_random();
    send_range(0, 6, 0);
    fill_random();
    build_exp();
    send_range(0, NPIX - 1, 0);
    drain_compare("sof_mid");

    // Reset with one result buffered and one in flight.
    bus.out_ready = 1'b0;
    fill_random();
    send_range(0, 11, 0);
    @(posedge clk);
    #1;
    check("prerst_out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_pix", bus.out_pix, 0);
    check("midrst_p5", p5, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("postrst_no_stale", got_q.size(), 0);
    check("postrst_out_valid", bus.out_valid, 0);
    check("postrst_in_ready", bus.in_ready, 1);
    got_q.delete();

    fill_vec(vecs[5]);
    build_exp();
    send_range(0, NPIX - 1, 0);
    drain_compare("recover");

`ifdef SOBEL_THRESH_EN
    thresh = 8'd50;
    core_force_en = 1'b1;
    core_force_val = 8'd49;
    fill_vec(vecs[0]);
    for (int k = 0; k < NRES; k++) exp_q.push_back({8'h00, k == NRES - 1});
    send_range(0, NPIX - 1, 0);
    drain_compare("thresh49");
    core_force_val = 8'd50;
    for (int k = 0; k < NRES; k++) exp_q.push_back({8'hFF, k == NRES - 1});
    send_range(0, NPIX - 1, 0);
    drain_compare("thresh50");
    core_force_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
